// File: rtl/spi_flash_reader.sv
// Single-IO SPI flash read initiator: wakes the flash with 0xAB, then
// serves 32-bit little-endian reads using command 0x03 + 24-bit address.
module spi_flash_reader #(
  parameter int CLK_DIV  = 1,
  parameter int CSB_HIGH = 4
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0_do,
  output logic        flash_io0_oeb,
  input  logic        flash_io1_di
);

  typedef enum logic [2:0] {
    INIT_START,
    SETUP,
    SHIFT,
    HOLD,
    GAP,
    IDLE
  } state_t;

  localparam logic [15:0] DIV    = 16'(CLK_DIV);
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_M1 = 16'(CSB_HIGH - 1);

  state_t      state, state_n;
  logic [15:0] div, div_n;
  logic [6:0]  nfall, nfall_n;
  logic [31:0] tx, tx_n;
  logic [31:0] rx, rx_n;
  logic        is_init, is_init_n;
  logic        csb_n, sck_n, mosi_n, oeb_n;
  logic        rv_n;
  logic [31:0] rd_n;
  logic        last_fall;

  assign req_ready = (state == IDLE);
  assign last_fall = (nfall == (is_init ? 7'd7 : 7'd63));

  always_comb begin
    state_n   = state;
    div_n     = div;
    nfall_n   = nfall;
    tx_n      = tx;
    rx_n      = rx;
    is_init_n = is_init;
    csb_n     = flash_csb;
    sck_n     = flash_clk;
    mosi_n    = flash_io0_do;
    oeb_n     = flash_io0_oeb;
    rv_n      = 1'b0;
    rd_n      = resp_data;
    unique case (state)
      INIT_START: begin
        state_n   = SETUP;
        div_n     = '0;
        nfall_n   = '0;
        tx_n      = {8'hAB, 24'h0};
        is_init_n = 1'b1;
      end
      IDLE: begin
        if (req_valid) begin
          state_n   = SETUP;
          div_n     = '0;
          nfall_n   = '0;
          tx_n      = {8'h03, req_addr};
          is_init_n = 1'b0;
        end
      end
      SETUP: begin
        div_n = div + 16'd1;
        // first SETUP cycle drops csb; N cycles later the first rise
        if (div == '0) begin
          csb_n  = 1'b0;
          oeb_n  = 1'b0;
          mosi_n = tx[31];
        end
        if (div == DIV) begin
          sck_n   = 1'b1;
          rx_n    = {rx[30:0], flash_io1_di};
          div_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        div_n = div + 16'd1;
        if (div == DIV_M1) begin
          div_n = '0;
          if (flash_clk) begin
            sck_n   = 1'b0;
            tx_n    = {tx[30:0], 1'b0};
            mosi_n  = tx[30];
            nfall_n = nfall + 7'd1;
            if (last_fall) begin
              mosi_n  = 1'b0;
              state_n = HOLD;
            end
          end else begin
            sck_n = 1'b1;
            rx_n  = {rx[30:0], flash_io1_di};
          end
        end
      end
      HOLD: begin
        div_n = div + 16'd1;
        if (div == DIV_M1) begin
          csb_n   = 1'b1;
          oeb_n   = 1'b1;
          mosi_n  = 1'b0;
          div_n   = '0;
          state_n = GAP;
          // rx holds bytes first-received-highest; swap to little-endian
          if (!is_init) begin
            rv_n = 1'b1;
            rd_n = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
          end
        end
      end
      GAP: begin
        div_n = div + 16'd1;
        if (div == GAP_M1) begin
          div_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = INIT_START;
    endcase
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state         <= INIT_START;
      div           <= '0;
      nfall         <= '0;
      tx            <= '0;
      rx            <= '0;
      is_init       <= 1'b1;
      flash_csb     <= 1'b1;
      flash_clk     <= 1'b0;
      flash_io0_do  <= 1'b0;
      flash_io0_oeb <= 1'b1;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
    end else begin
      state         <= state_n;
      div           <= div_n;
      nfall         <= nfall_n;
      tx            <= tx_n;
      rx            <= rx_n;
      is_init       <= is_init_n;
      flash_csb     <= csb_n;
      flash_clk     <= sck_n;
      flash_io0_do  <= mosi_n;
      flash_io0_oeb <= oeb_n;
      resp_valid    <= rv_n;
      resp_data     <= rd_n;
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: two instances (CLK_DIV 1 and 3),
// each with a behavioural mode-0 flash and a bus monitor.
module tb_spi_flash_reader;

  localparam int CSB_HIGH = 4;

  logic             clk = 1'b0;
  logic [1:0]       rst = 2'b11;
  logic [1:0]       req_valid = '0;
  logic [1:0][23:0] req_addr = '0;
  logic [1:0]       ready, rv, csb, sck, io0, oeb;
  logic [1:0][31:0] rd;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int N = (g == 0) ? 1 : 3;
    logic        io1 = 1'b0;
    logic [7:0]  mem [16];
    logic [7:0]  b;
    logic [31:0] sh = '0;
    logic [31:0] sent = '0;
    logic [31:0] slog [8];
    logic [31:0] rlog [8];
    logic        prev_csb = 1'b1;
    logic        prev_sck = 1'b0;
    int cyc = 0, hs_cyc = 0, rises = 0, nrises = 0, idx = 0;
    int period = 0, rise_cyc = 0, hi_run = 0, last_gap = 0;
    int ntx = 0, nrv = 0, lat = 0, viol = 0;

    spi_flash_reader #(.CLK_DIV(N), .CSB_HIGH(CSB_HIGH)) dut (
      .core_clk      (clk),
      .core_rst      (rst[g]),
      .req_valid     (req_valid[g]),
      .req_ready     (ready[g]),
      .req_addr      (req_addr[g]),
      .resp_valid    (rv[g]),
      .resp_data     (rd[g]),
      .flash_csb     (csb[g]),
      .flash_clk     (sck[g]),
      .flash_io0_do  (io0[g]),
      .flash_io0_oeb (oeb[g]),
      .flash_io1_di  (io1)
    );

    initial forever begin
      @(posedge clk);
      if (req_valid[g] && ready[g]) hs_cyc = cyc;
    end

    initial forever begin
      @(negedge clk);
      cyc++;
      if (!csb[g] && prev_csb) begin
        rises = 0;
        sh = '0;
        last_gap = hi_run;
      end
      if (csb[g]) hi_run++;
      else hi_run = 0;
      if (!csb[g] && sck[g] && !prev_sck) begin
        if (rises < 32) sh = {sh[30:0], io0[g]};
        rises++;
        period = cyc - rise_cyc;
        rise_cyc = cyc;
      end
      if (!csb[g] && !sck[g] && prev_sck && rises >= 32 && rises < 64) begin
        idx = rises - 32;
        b = mem[4'(sh[3:0] + 4'(idx / 8))];
        io1 = b[7 - idx % 8];
      end
      if (csb[g] && !prev_csb) begin
        sent = sh;
        nrises = rises;
        if (ntx < 8) slog[ntx] = sh;
        ntx++;
      end
      if (csb[g] && io0[g]) viol++;
      if (csb[g] && prev_csb && sck[g] != prev_sck) viol++;
      if (rv[g]) begin
        lat = cyc - hs_cyc - 1;
        if (nrv < 8) rlog[nrv] = rd[g];
        nrv++;
      end
      prev_csb = csb[g];
      prev_sck = sck[g];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic hs(input int g);
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk);
      if (ready[g]) ok = 1'b1;
    end
    #1;
    chk("hs_timeout", 64'(ok), 1);
  endtask

  task automatic req(input int g, input logic [23:0] a);
    @(negedge clk);
    req_valid[g] = 1'b1;
    req_addr[g] = a;
    hs(g);
    req_valid[g] = 1'b0;
  endtask

  task automatic wait_nrv(input int g, input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      tick();
      if ((g == 0 ? u[0].nrv : u[1].nrv) >= target) ok = 1'b1;
    end
    chk("resp_timeout", 64'(ok), 1);
  endtask

  task automatic wait_ready(input int g);
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      tick();
      if (ready[g]) ok = 1'b1;
    end
    chk("ready_timeout", 64'(ok), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int csb_up, rdy_up, base_rv, base_tx;
    repeat (3) tick();
    chk("rst_csb", 64'(csb[0]), 1);
    chk("rst_sck", 64'(sck[0]), 0);
    chk("rst_io0", 64'(io0[0]), 0);
    chk("rst_oeb", 64'(oeb[0]), 1);
    chk("rst_ready", 64'(ready[0]), 0);
    chk("rst_rv", 64'(rv[0]), 0);
    chk("rst_rd", 64'(rd[0]), 0);

    // init sequence on N=1
    @(posedge clk);
    #1 rst = 2'b00;
    csb_up = -1;
    rdy_up = -1;
    for (int i = 0; i < 300 && rdy_up < 0; i++) begin
      tick();
      if (csb_up < 0 && u[0].ntx == 1) csb_up = i;
      if (ready[0]) rdy_up = i;
    end
    chk("init_rises", 64'(u[0].nrises), 8);
    chk("init_cmd", 64'(u[0].sent[7:0]), 64'h0AB);
    chk("init_gap", 64'(rdy_up - csb_up), CSB_HIGH);
    chk("init_no_resp", 64'(u[0].nrv), 0);
    wait_ready(1);
    chk("init1_rises", 64'(u[1].nrises), 8);
    chk("init1_cmd", 64'(u[1].sent[7:0]), 64'h0AB);

    // read at 0x000000, N=1
    for (int i = 0; i < 16; i++) u[0].mem[i] = 8'h00;
    u[0].mem[0] = 8'h6f;
    u[0].mem[3] = 8'h0b;
    req(0, 24'h000000);
    wait_nrv(0, 1);
    chk("rd0_data", 64'(rd[0]), 64'h0b00006f);
    chk("rd0_lat", 64'(u[0].lat), 130);
    chk("rd0_sent", 64'(u[0].sent), 64'h03000000);
    chk("rd0_period", 64'(u[0].period), 2);
    tick();
    chk("rd0_pulse", 64'(rv[0]), 0);
    chk("rd0_rises", 64'(u[0].nrises), 64);

    // read at 0x123456, N=3
    for (int i = 0; i < 16; i++) u[1].mem[i] = 8'h00;
    u[1].mem[6] = 8'h11;
    u[1].mem[7] = 8'h22;
    u[1].mem[8] = 8'h33;
    u[1].mem[9] = 8'h44;
    req(1, 24'h123456);
    wait_nrv(1, 1);
    chk("rd1_data", 64'(rd[1]), 64'h44332211);
    chk("rd1_lat", 64'(u[1].lat), 388);
    chk("rd1_sent", 64'(u[1].sent), 64'h03123456);
    chk("rd1_period", 64'(u[1].period), 6);

    // back-to-back with req_valid held
    for (int i = 0; i < 16; i++) u[0].mem[i] = 8'hA0 + 8'(i);
    base_rv = u[0].nrv;
    base_tx = u[0].ntx;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0] = 24'h000104;
    hs(0);
    req_addr[0] = 24'h00020A;
    hs(0);
    req_valid[0] = 1'b0;
    wait_nrv(0, base_rv + 2);
    repeat (5) tick();
    chk("b2b_count", 64'(u[0].nrv - base_rv), 2);
    chk("b2b_resp0", 64'(u[0].rlog[base_rv]), 64'hA7A6A5A4);
    chk("b2b_resp1", 64'(u[0].rlog[base_rv + 1]), 64'hADACABAA);
    chk("b2b_sent0", 64'(u[0].slog[base_tx]), 64'h03000104);
    chk("b2b_sent1", 64'(u[0].slog[base_tx + 1]), 64'h0300020A);
    chk("b2b_gap", 64'(u[0].last_gap >= CSB_HIGH), 1);

    // reset in the middle of a read
    base_rv = u[0].nrv;
    req(0, 24'h000000);
    for (int i = 0; i < 200 && u[0].rises != 20; i++) tick();
    chk("mid_reached", 64'(u[0].rises), 20);
    rst[0] = 1'b1;
    #1;
    chk("mid_csb", 64'(csb[0]), 1);
    chk("mid_sck", 64'(sck[0]), 0);
    chk("mid_oeb", 64'(oeb[0]), 1);
    chk("mid_io0", 64'(io0[0]), 0);
    chk("mid_ready", 64'(ready[0]), 0);
    repeat (2) tick();
    @(posedge clk);
    #1 rst[0] = 1'b0;
    wait_ready(0);
    chk("mid_reinit_rises", 64'(u[0].nrises), 8);
    chk("mid_reinit_cmd", 64'(u[0].sent[7:0]), 64'h0AB);
    chk("mid_no_resp", 64'(u[0].nrv), 64'(base_rv));

    // all-ones address and data
    for (int i = 0; i < 16; i++) u[0].mem[i] = 8'hFF;
    req(0, 24'hFFFFFF);
    wait_nrv(0, base_rv + 1);
    chk("ff_data", 64'(rd[0]), 64'hffffffff);
    chk("ff_sent", 64'(u[0].sent), 64'h03FFFFFF);
    chk("ff_lat", 64'(u[0].lat), 130);

    repeat (10) tick();
    chk("idle_io0_sck_0", 64'(u[0].viol), 0);
    chk("idle_io0_sck_1", 64'(u[1].viol), 0);
    chk("total_resp_0", 64'(u[0].nrv), 4);
    chk("total_resp_1", 64'(u[1].nrv), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Single-IO SPI flash read initiator for the management core's boot/instruction path.
- Drives the same pad group the mgmt core exposes: flash_csb, flash_clk, flash_io0_do/oeb, flash_io1_di.
- After reset, issues release-power-down (0xAB).
- Then serves 32-bit read requests with command 0x03 + 24-bit address + 4 data bytes, returning little-endian words.

Parameters:
- CLK_DIV, 1: flash_clk half-period in core_clk cycles (>=1).
- CSB_HIGH, 4: minimum core_clk cycles flash_csb stays high between transactions (>=1).

Ports:
- core_clk  input  1  system clock
- core_rst  input  1  asynchronous active-high reset
- req_valid  input  1  read request
- req_ready  output  1  request accepted when req_valid&&req_ready at core_clk edge
- req_addr  input  24  byte address, captured at handshake
- resp_valid  output  1  one-cycle pulse, resp_data valid
- resp_data  output  32  read word; byte at addr in [7:0], addr+3 in [31:24]
- flash_csb  output  1  chip select, active low
- flash_clk  output  1  SPI clock, mode 0 (idle low)
- flash_io0_do  output  1  MOSI
- flash_io0_oeb  output  1  io0 output enable, active low
- flash_io1_di  input  1  MISO

Behaviour:
- Reset (async, core_rst=1, any state including mid-transfer):
  - flash_csb=1, flash_clk=0, flash_io0_do=0, flash_io0_oeb=1.
  - req_ready=0, resp_valid=0, resp_data=0.
  - FSM returns to INIT_START; a partial transfer is abandoned, no resp_valid.
- States: INIT_START, SETUP, SHIFT, HOLD, GAP, IDLE.
- Transaction timing (N=CLK_DIV, handshake at edge t0):
  - After edge t0+1: flash_csb=0, flash_io0_oeb=0, flash_io0_do = MSB of shift word, flash_clk=0 (SETUP, N cycles).
  - SHIFT: flash_clk toggles every N cycles, starting high.
  - flash_io1_di is sampled at the core_clk edge that drives flash_clk 0->1.
  - flash_io0_do updates at the edge that drives flash_clk 1->0.
  - After the last falling edge, HOLD lasts N cycles with flash_clk=0.
  - Then flash_csb=1 and flash_io0_oeb=1; GAP begins.
- Read transaction:
  - 64 SCK cycles: 0x03, then req_addr[23:0], MSB first, then 32 input bits.
  - Input bits assemble as bytes: first 8 bits received -> resp_data[7:0] (bit7 first), next byte -> [15:8], and so on.
  - resp_valid=1 for exactly one cycle, in the cycle flash_csb returns high.
  - resp_data holds its value until the next resp_valid.
  - Handshake-to-resp_valid latency = 1 + 129*N cycles (130 for N=1).
- Init transaction:
  - Entered on reset release.
  - 8 SCK cycles sending 0xAB with the same SETUP/HOLD timing; no resp_valid.
- GAP:
  - flash_csb stays high for CSB_HIGH cycles, then IDLE.
  - req_ready=1 only in IDLE.
  - First handshake is possible no earlier than CSB_HIGH cycles after init csb rise.
- Valid/ready rules:
  - req_valid while req_ready=0 is ignored; requester must hold it.
  - req_addr changes during a transfer have no effect.
  - No backpressure on resp_valid.
  - req_ready drops in the cycle after handshake.
- Boundaries:
  - req_addr=0xFFFFFF is sent unmodified; wrap of addr+1..3 is the flash's concern.
  - flash_io0_do is 0 whenever flash_csb=1.
  - flash_clk never toggles while flash_csb=1.

Test Plan:
- Reset release, N=1 -> csb low for exactly 8 SCK rises; io0 bits at rises = 1010_1011 (0xAB); csb high; req_ready rises exactly CSB_HIGH cycles later; resp_valid never asserted.
- Flash model bytes 0x6f,0x00,0x00,0x0b at 0x000000; request addr 0x000000 -> io0 at rises 0x03 then 0x000000; resp_valid 130 cycles after handshake; resp_data=0x0b00006f.
- CLK_DIV=3, addr 0x123456, bytes 0x11,0x22,0x33,0x44:
  - io0 shows 0x03 then 0x123456.
  - flash_clk period 6 cycles.
  - resp_valid at handshake+388.
  - resp_data=0x44332211.
- Back-to-back: req_valid held high with two addresses:
  - exactly two resp_valid pulses, in order;
  - csb high >= CSB_HIGH cycles between transactions;
  - second req_addr captured only at the second handshake.
- Assert core_rst at the 20th SCK rise of a read -> csb=1, clk=0, oeb=1 immediately, no resp_valid; after release, 0xAB is re-sent before req_ready=1.
- Flash model returns 0xFF bytes at addr 0xFFFFFF -> address bits all 1 on io0; resp_data=0xffffffff; io0=0 and flash_clk static while csb high throughout.
